pdp11_trace_buf: RTL and testbench
==================================

PDP11_TRACE_BUF -- requirements
Module: pdp11_trace_buf

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, PC width.
REQ-002 SHALL have parameter PSW_W, default 16, PSW width.
REQ-003 SHALL have parameter IST_W, default 4, istate width.
REQ-004 SHALL have parameter DEPTH_LOG2, default 6, buffer depth = 2**DEPTH_LOG2 entries.
REQ-005 SHALL have parameter CYC_W, default 32, cycle counter width.
REQ-006 SHALL have parameters FETCH_STATE, default 1, and HALT_STATE, default 0, which are istate codes.
REQ-007 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-009 SHALL have port enable  input  1  capture enable.
REQ-010 SHALL have port clear  input  1  synchronous flush.
REQ-011 SHALL have ports istate, pc and psw, all inputs, of widths IST_W, ADDR_W and PSW_W, carrying CPU state.
REQ-012 SHALL have port rd_en  input  1  pop request.
REQ-013 SHALL have ports rd_valid (output, 1), rd_pc (output, ADDR_W), rd_psw (output, PSW_W) and rd_cycle (output, CYC_W), carrying popped entry data.
REQ-014 SHALL have port count  output  DEPTH_LOG2+1  number of occupied entries.
REQ-015 SHALL have ports overflow (output, 1, sticky), halted (output, 1, sticky) and halt_cycle (output, CYC_W), the cycle at which the halt occurred.
REQ-016 SHALL have port cycle  output  CYC_W  free-running count of clocks since reset.

Function
REQ-017 cycle SHALL increment by 1 every clock and saturate at all-ones.
REQ-018 Capture SHALL occur when enable=1, halted=0 and istate==FETCH_STATE. A capture writes {pc, psw, cycle} at the write pointer, which then advances modulo depth.
REQ-019 A capture into a non-full buffer SHALL increment count.
REQ-020 A capture into a full buffer with no pop SHALL overwrite the oldest entry, advance the read pointer, leave count at depth, and set overflow.
REQ-021 rd_en with count>0 SHALL pop the oldest entry; rd_valid=1 and rd_* data SHALL appear on the following cycle only.
REQ-022 rd_en with count==0 SHALL be ignored, and rd_valid SHALL be 0 on the next cycle.
REQ-023 A simultaneous capture and pop SHALL leave count unchanged, SHALL NOT set overflow, and the pop SHALL return the pre-capture oldest entry, including at count==1 and when the buffer is full.
REQ-024 An internal armed flag SHALL set on the first cycle with istate!=HALT_STATE. When armed=1 and istate==HALT_STATE, halted SHALL set and halt_cycle SHALL latch cycle, and further captures SHALL stop.
REQ-025 A halt cycle SHALL NOT itself be captured.
REQ-026 clear SHALL empty the buffer and zero the pointers, count, overflow, halted, armed and rd_valid, without resetting cycle.
REQ-027 clear SHALL take priority over a same-cycle capture or pop.
REQ-028 Pointer wrap SHALL occur at 2**DEPTH_LOG2-1 -> 0.

Reset
REQ-029 reset asserted SHALL immediately force: cycle=0, count=0, pointers=0, rd_valid=0, rd_pc/rd_psw/rd_cycle=0, overflow=0, halted=0, halt_cycle=0, armed=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; buffer RAM contents need not be cleared.

Configuration
REQ-031 With macro PDP11_TRACE_TIMESTAMP_EN defined, entries SHALL store cycle and rd_cycle SHALL return it.
REQ-032 Without that macro, the entry SHALL omit the cycle field and rd_cycle SHALL be constant 0. The cycle, halt_cycle and the halt logic SHALL be unaffected.

Structure
REQ-033 Package pdp11_trace_pkg SHALL hold the entry struct typedef and the default FETCH_STATE/HALT_STATE constants.
REQ-034 Entry storage SHALL be one sub-module, trace_ram: simple dual-port, synchronous read, 2**DEPTH_LOG2 x entry width.

Verification (DEPTH_LOG2=2, CYC_W=16, timestamp enabled)
REQ-035 Reset, then istate=1 with pc=o1000,o1002,o1004 on cycles 5,6,7, then 3 pops -> rd_pc=o1000,o1002,o1004, rd_cycle=5,6,7, count 3->0.
REQ-036 6 captures with pc=1..6 and no pops -> count=4, overflow=1, pops return pc 3,4,5,6.
REQ-037 Capture and rd_en in the same cycle at count=4 (full) -> count stays 4, overflow=0, pop returns the oldest entry.
REQ-038 istate 0 at reset, then 1,1, then 0 at cycle 10 -> halted=1, halt_cycle=10, count=2, no capture afterwards.
REQ-039 rd_en at count=0 -> rd_valid=0; clear at count=3 with overflow=1 -> count=0, overflow=0, cycle keeps counting.
REQ-040 reset pulse mid-stream at count=2 -> all outputs 0 immediately, next capture lands at entry 0.

Source files
------------

// File: rtl/pdp11_trace_pkg.sv
// Shared definitions for the PDP-11 instruction trace buffer.
// The default istate codes for "instruction fetch" and "halt" live here.
// trace_entry_t is the entry layout at the default widths with the timestamp
// included, for tools and software that decode a dumped buffer.
package pdp11_trace_pkg;

    localparam int unsigned TRACE_FETCH_STATE = 32'd1;
    localparam int unsigned TRACE_HALT_STATE  = 32'd0;

    localparam int unsigned TRACE_DEF_ADDR_W = 32'd16;
    localparam int unsigned TRACE_DEF_PSW_W  = 32'd16;
    localparam int unsigned TRACE_DEF_CYC_W  = 32'd32;

    typedef struct packed {
        logic [TRACE_DEF_ADDR_W-1:0] pc;
        logic [TRACE_DEF_PSW_W-1:0]  psw;
        logic [TRACE_DEF_CYC_W-1:0]  cyc;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port entry storage for the trace buffer: one write port and one
// synchronous read port. A same-cycle read and write of one address returns the
// old contents. This lets a pop on a full buffer see the oldest entry while a
// capture overwrites it.
module trace_ram #(
    parameter int unsigned AW = 32'd6,
    parameter int unsigned DW = 32'd64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    // Write port: the storage array itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: registered, updated only on a read so popped data is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= {DW{1'b0}};
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pdp11_trace_buf.sv
// PDP-11 instruction trace buffer. It captures {pc, psw, cycle} on every fetch
// into a circular buffer, overwrites the oldest entry when full, and freezes on CPU halt.
// Optional feature macro: PDP11_TRACE_TIMESTAMP_EN. It stores the cycle stamp
// in each entry. Without it, rd_cycle reads as 0.
module pdp11_trace_buf
    import pdp11_trace_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32'd16,
    parameter int unsigned PSW_W       = 32'd16,
    parameter int unsigned IST_W       = 32'd4,
    parameter int unsigned DEPTH_LOG2  = 32'd6,
    parameter int unsigned CYC_W       = 32'd32,
    parameter int unsigned FETCH_STATE = TRACE_FETCH_STATE,
    parameter int unsigned HALT_STATE  = TRACE_HALT_STATE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [IST_W-1:0]      istate,
    input  logic [ADDR_W-1:0]     pc,
    input  logic [PSW_W-1:0]      psw,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [ADDR_W-1:0]     rd_pc,
    output logic [PSW_W-1:0]      rd_psw,
    output logic [CYC_W-1:0]      rd_cycle,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  halted,
    output logic [CYC_W-1:0]      halt_cycle,
    output logic [CYC_W-1:0]      cycle
);

    localparam int unsigned            DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    DEPTH_C    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]    CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0]  PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [CYC_W-1:0]       CYC_ONE    = CYC_W'(1);
    localparam logic [CYC_W-1:0]       CYC_MAX    = {CYC_W{1'b1}};
    localparam logic [IST_W-1:0]       FETCH_CODE = IST_W'(FETCH_STATE);
    localparam logic [IST_W-1:0]       HALT_CODE  = IST_W'(HALT_STATE);

`ifdef PDP11_TRACE_TIMESTAMP_EN
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [PSW_W-1:0]  psw;
        logic [CYC_W-1:0]  cyc;
    } entry_t;
`else
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [PSW_W-1:0]  psw;
    } entry_t;
`endif

    localparam int unsigned ENTRY_W = $bits(entry_t);

    logic [CYC_W-1:0]      cycle_q, cycle_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  halted_q, halted_d;
    logic                  armed_q, armed_d;
    logic [CYC_W-1:0]      halt_cycle_q, halt_cycle_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  halt_event_s;
    logic                  capture_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  ram_we_s;
    logic                  ram_re_s;
    entry_t                wr_entry_s;
    entry_t                rd_entry_s;
    logic [ENTRY_W-1:0]    ram_rdata_s;

    // Event decode: halt detection, capture qualification and pop acceptance.
    always_comb begin
        halt_event_s = armed_q && !halted_q && (istate == HALT_CODE);
        capture_s    = enable && !halted_q && (istate == FETCH_CODE) && !halt_event_s;
        pop_s        = rd_en && (count_q != {(DEPTH_LOG2 + 1){1'b0}});
        full_s       = (count_q == DEPTH_C);
        ram_we_s     = capture_s && !clear;
        ram_re_s     = pop_s && !clear;
    end

    // Entry assembly for the write port.
    always_comb begin
        wr_entry_s     = '0;
        wr_entry_s.pc  = pc;
        wr_entry_s.psw = psw;
`ifdef PDP11_TRACE_TIMESTAMP_EN
        wr_entry_s.cyc = cycle_q;
`endif
    end

    // Next-state logic. Clear wins over capture and pop. The cycle counter ignores clear.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        halted_d     = halted_q;
        armed_d      = armed_q;
        halt_cycle_d = halt_cycle_q;
        rd_valid_d   = 1'b0;

        if (cycle_q != CYC_MAX) begin
            cycle_d = cycle_q + CYC_ONE;
        end else begin
            cycle_d = cycle_q;
        end

        if (clear) begin
            wptr_d     = {DEPTH_LOG2{1'b0}};
            rptr_d     = {DEPTH_LOG2{1'b0}};
            count_d    = {(DEPTH_LOG2 + 1){1'b0}};
            overflow_d = 1'b0;
            halted_d   = 1'b0;
            armed_d    = 1'b0;
        end else begin
            rd_valid_d = pop_s;

            if (capture_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end

            // A pop and a full-buffer overwrite both retire the oldest entry.
            if (pop_s || (capture_s && full_s)) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end

            if (capture_s && full_s && !pop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end

            if (capture_s && !pop_s && !full_s) begin
                count_d = count_q + CNT_ONE;
            end else if (pop_s && !capture_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end

            if (istate != HALT_CODE) begin
                armed_d = 1'b1;
            end else begin
                armed_d = armed_q;
            end

            if (halt_event_s) begin
                halted_d     = 1'b1;
                halt_cycle_d = cycle_q;
            end else begin
                halted_d     = halted_q;
                halt_cycle_d = halt_cycle_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q      <= {CYC_W{1'b0}};
            wptr_q       <= {DEPTH_LOG2{1'b0}};
            rptr_q       <= {DEPTH_LOG2{1'b0}};
            count_q      <= {(DEPTH_LOG2 + 1){1'b0}};
            overflow_q   <= 1'b0;
            halted_q     <= 1'b0;
            armed_q      <= 1'b0;
            halt_cycle_q <= {CYC_W{1'b0}};
            rd_valid_q   <= 1'b0;
        end else begin
            cycle_q      <= cycle_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            halted_q     <= halted_d;
            armed_q      <= armed_d;
            halt_cycle_q <= halt_cycle_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    trace_ram #(
        .AW (DEPTH_LOG2),
        .DW (ENTRY_W)
    ) u_trace_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we_s),
        .waddr (wptr_q),
        .wdata (wr_entry_s),
        .re    (ram_re_s),
        .raddr (rptr_q),
        .rdata (ram_rdata_s)
    );

    assign rd_entry_s = entry_t'(ram_rdata_s);
    assign rd_valid   = rd_valid_q;
    assign rd_pc      = rd_entry_s.pc;
    assign rd_psw     = rd_entry_s.psw;
`ifdef PDP11_TRACE_TIMESTAMP_EN
    assign rd_cycle   = rd_entry_s.cyc;
`else
    assign rd_cycle   = {CYC_W{1'b0}};
`endif
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign halted     = halted_q;
    assign halt_cycle = halt_cycle_q;
    assign cycle      = cycle_q;

endmodule

// File: tb/tb_pdp11_trace_buf.sv
// Self-checking bench for pdp11_trace_buf (DEPTH_LOG2=2, CYC_W=16).
// The reference model is a queue of entries updated from the behavioural rules.
module tb_pdp11_trace_buf;

    localparam int AW    = 16;
    localparam int PW    = 16;
    localparam int IW    = 4;
    localparam int DL    = 2;
    localparam int CW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          clear;
    logic [IW-1:0] istate;
    logic [AW-1:0] pc;
    logic [PW-1:0] psw;
    logic          rd_en;
    logic          rd_valid;
    logic [AW-1:0] rd_pc;
    logic [PW-1:0] rd_psw;
    logic [CW-1:0] rd_cycle;
    logic [DL:0]   count;
    logic          overflow;
    logic          halted;
    logic [CW-1:0] halt_cycle;
    logic [CW-1:0] cycle;

    pdp11_trace_buf #(
        .DEPTH_LOG2 (DL),
        .CYC_W      (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .istate     (istate),
        .pc         (pc),
        .psw        (psw),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_pc      (rd_pc),
        .rd_psw     (rd_psw),
        .rd_cycle   (rd_cycle),
        .count      (count),
        .overflow   (overflow),
        .halted     (halted),
        .halt_cycle (halt_cycle),
        .cycle      (cycle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] psw;
        logic [15:0] cyc;
    } ent_t;

    ent_t        q[$];
    int unsigned m_cycle;
    bit          m_ovf, m_halted, m_armed, m_valid;
    logic [15:0] m_hcyc;
    ent_t        m_rd;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cycle  = 0;
        m_ovf    = 1'b0;
        m_halted = 1'b0;
        m_armed  = 1'b0;
        m_valid  = 1'b0;
        m_hcyc   = 16'd0;
        m_rd     = '{16'd0, 16'd0, 16'd0};
    endtask

    // One rising edge of behaviour, using the inputs held across that edge.
    task automatic model_edge();
        ent_t e;
        bit   halt_ev, cap, pop;
        if (clear) begin
            q.delete();
            m_ovf    = 1'b0;
            m_halted = 1'b0;
            m_armed  = 1'b0;
            m_valid  = 1'b0;
        end else begin
            halt_ev = m_armed && !m_halted && (istate == 4'd0);
            cap     = enable && !m_halted && (istate == 4'd1) && !halt_ev;
            pop     = rd_en && (q.size() > 0);
            m_valid = pop;
            if (pop) m_rd = q.pop_front();
            if (cap) begin
                if (q.size() == DEPTH) begin
                    q.delete(0);
                    m_ovf = 1'b1;
                end
                e.pc  = pc;
                e.psw = psw;
                e.cyc = m_cycle[15:0];
                q.push_back(e);
            end
            if (istate != 4'd0) m_armed = 1'b1;
            if (halt_ev) begin
                m_halted = 1'b1;
                m_hcyc   = m_cycle[15:0];
            end
        end
        if (m_cycle != 32'hFFFF) m_cycle++;
    endtask

    task automatic check_all();
        check_eq("count", 64'(count), 64'(q.size()));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("halted", 64'(halted), 64'(m_halted));
        check_eq("halt_cycle", 64'(halt_cycle), 64'(m_hcyc));
        check_eq("cycle", 64'(cycle), 64'(m_cycle));
        check_eq("rd_valid", 64'(rd_valid), 64'(m_valid));
        check_eq("rd_pc", 64'(rd_pc), 64'(m_rd.pc));
        check_eq("rd_psw", 64'(rd_psw), 64'(m_rd.psw));
`ifdef PDP11_TRACE_TIMESTAMP_EN
        check_eq("rd_cycle", 64'(rd_cycle), 64'(m_rd.cyc));
`else
        check_eq("rd_cycle", 64'(rd_cycle), 64'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic drive(input bit en, input logic [3:0] ist, input logic [15:0] p,
                         input bit rd, input bit clr);
        enable = en;
        istate = ist;
        pc     = p;
        psw    = 16'($urandom);
        rd_en  = rd;
        clear  = clr;
        step();
    endtask

    // Asynchronous reset pulse; outputs must drop without waiting for an edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int r;
        logic [3:0] ist;
        reset  = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        istate = 4'd0;
        pc     = 16'd0;
        psw    = 16'd0;
        rd_en  = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Three fetches stamped at cycles 5, 6, 7, then drained in order.
        for (int i = 0; i < 5; i++) drive(1'b1, 4'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'o1000, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'o1002, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'o1004, 1'b0, 1'b0);
        check_eq("first_count3", 64'(count), 64'd3);
        drive(1'b1, 4'd2, 16'd0, 1'b1, 1'b0);
        check_eq("first_pop_pc", 64'(rd_pc), 64'o1000);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd2, 16'd0, 1'b1, 1'b0);

        // Six captures into four entries: overwrite the oldest.
        drive(1'b0, 4'd2, 16'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) drive(1'b1, 4'd1, 16'(i), 1'b0, 1'b0);
        check_eq("wrap_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 5; i++) drive(1'b1, 4'd2, 16'd0, 1'b1, 1'b0);

        // Capture and pop together at full and at count 1.
        drive(1'b0, 4'd2, 16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'd1, 16'(16'h100 + i), 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'h1AA, 1'b1, 1'b0);
        check_eq("full_cappop_ovf", 64'(overflow), 64'd0);
        check_eq("full_cappop_pc", 64'(rd_pc), 64'h100);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd2, 16'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 16'h1BB, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 16'h1CC, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 16'h1DD, 1'b1, 1'b0);

        // Halt: idle in HALT until armed by fetches, then HALT at cycle 10.
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 4'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'o2000, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'o2002, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 16'o2004, 1'b0, 1'b0);
        check_eq("halt_flag", 64'(halted), 64'd1);
        check_eq("halt_at10", 64'(halt_cycle), 64'd10);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd1, 16'o3000, 1'b0, 1'b0);
        check_eq("halt_nocap", 64'(count), 64'd2);

        // Pop while empty, then clear at count 3 with overflow set.
        drive(1'b0, 4'd2, 16'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd2, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 4'd1, 16'(16'h300 + i), 1'b0, 1'b0);
        drive(1'b0, 4'd2, 16'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 16'h3FF, 1'b1, 1'b1);
        check_eq("clear_count", 64'(count), 64'd0);
        drive(1'b0, 4'd2, 16'd0, 1'b0, 1'b0);

        // Reset mid-stream at count 2; next capture must come back first.
        drive(1'b1, 4'd1, 16'h400, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'h401, 1'b0, 1'b0);
        enable = 1'b0;
        do_reset();
        drive(1'b1, 4'd1, 16'h4AA, 1'b0, 1'b0);
        drive(1'b0, 4'd2, 16'd0, 1'b1, 1'b0);
        check_eq("post_reset_pc", 64'(rd_pc), 64'h4AA);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4)       ist = 4'd0;
            else if (r < 70) ist = 4'd1;
            else             ist = 4'(2 + $urandom_range(0, 13));
            drive($urandom_range(0, 3) != 0, ist, 16'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
            if (i == 300) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
